// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue unit.
// Holds the word and register widths, the opcode values, the instruction field
// bit positions, the FSM state encoding and the issue packet layout.
package alu_issue_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 16;

  // Instruction word fields: [15:13] opcode, [12:10] Rd, [9:7] Rs, [6:0] ignored
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 7;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_LDM = 3'd1;
  localparam logic [OP_W-1:0] OP_STD = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_NOT = 3'd4;

  // S_OP expects an opcode word, S_IMM expects the LDM immediate word
  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] immediate;
    logic [REG_AW-1:0] dst_addr;
    logic              wb_en;
  } issue_pkt_t;

  // Opcodes that issue a packet from a single word
  function automatic logic is_single_issue(logic [OP_W-1:0] op);
    return (op == OP_STD) || (op == OP_ADD) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction input handshake, the register-file read ports and
// the issue packet handshake toward the ALU stage.
//   master: the issue unit (consumes instructions, produces the ALU packet)
//   slave : the surrounding fetch / register file / ALU environment
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic              instr_valid;
  logic [DATA_W-1:0] instr_word;
  logic              instr_ready;

  logic [REG_AW-1:0] rf_rs_addr;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rd_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [OP_W-1:0]   ex_alu_op;
  logic [DATA_W-1:0] ex_rs;
  logic [DATA_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_immediate;
  logic [REG_AW-1:0] ex_dst_addr;
  logic              ex_wb_en;

  modport master (
    input  instr_valid, instr_word, rf_rs_data, rf_rd_data, ex_ready,
    output instr_ready, rf_rs_addr, rf_rd_addr,
    output ex_valid, ex_alu_op, ex_rs, ex_rd, ex_immediate, ex_dst_addr, ex_wb_en
  );

  modport slave (
    output instr_valid, instr_word, rf_rs_data, rf_rd_data, ex_ready,
    input  instr_ready, rf_rs_addr, rf_rd_addr,
    input  ex_valid, ex_alu_op, ex_rs, ex_rd, ex_immediate, ex_dst_addr, ex_wb_en
  );

endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational field decoder for one instruction word.
//   instr_word  : raw 16-bit word
//   opcode      : bits [15:13]
//   rd_addr     : bits [12:10]
//   rs_addr     : bits [9:7]
//   is_two_word : LDM, the next word is an immediate
//   is_illegal  : opcode 5..7
//   wb_en       : the instruction writes a register back
module instr_field_decode
  import alu_issue_pkg::*;
(
  input  logic [DATA_W-1:0] instr_word,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_AW-1:0] rd_addr,
  output logic [REG_AW-1:0] rs_addr,
  output logic              is_two_word,
  output logic              is_illegal,
  output logic              wb_en
);

  assign opcode  = instr_word[OPC_MSB:OPC_LSB];
  assign rd_addr = instr_word[RD_MSB:RD_LSB];
  assign rs_addr = instr_word[RS_MSB:RS_LSB];

  // Low bits carry no meaning for this unit
  logic unused_low_bits;
  assign unused_low_bits = ^instr_word[RS_LSB-1:0];

  always_comb begin
    is_two_word = 1'b0;
    is_illegal  = 1'b0;
    wb_en       = 1'b0;
    unique case (opcode)
      OP_NOP: ;
      OP_LDM: begin
        is_two_word = 1'b1;
        wb_en       = 1'b1;
      end
      OP_STD: ;
      OP_ADD: wb_en = 1'b1;
      OP_NOT: wb_en = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Execute-stage front end: accepts instruction words, reads two register-file
// ports, assembles two-word LDM instructions and presents one registered issue
// packet to the ALU stage.
//   clk, rst_n    : clock and asynchronous active-low reset
//   flush         : drops the held packet and any half-assembled LDM
//   bus (master)  : instruction handshake, register-file reads, issue packet
//   illegal_instr : one-cycle pulse after an illegal opcode is consumed
//   issue_count   : wrapping count of packets taken by the ALU stage
module alu_issue_unit
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_if.master      bus,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] issue_count
);

  logic [OP_W-1:0]   dec_opcode;
  logic [REG_AW-1:0] dec_rd_addr;
  logic [REG_AW-1:0] dec_rs_addr;
  logic              dec_is_two_word;
  logic              dec_is_illegal;
  logic              dec_wb_en;

  instr_field_decode u_decode (
    .instr_word  (bus.instr_word),
    .opcode      (dec_opcode),
    .rd_addr     (dec_rd_addr),
    .rs_addr     (dec_rs_addr),
    .is_two_word (dec_is_two_word),
    .is_illegal  (dec_is_illegal),
    .wb_en       (dec_wb_en)
  );

  assign bus.rf_rs_addr = dec_rs_addr;
  assign bus.rf_rd_addr = dec_rd_addr;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] ldm_rd_q, ldm_rd_d;
  logic              ex_valid_q, ex_valid_d;
  issue_pkt_t        pkt_q, pkt_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic       advance;
  logic       accept;
  logic       issue;
  issue_pkt_t pkt_new;

  // The packet register can take a new value when empty or being consumed
  assign advance         = !ex_valid_q || bus.ex_ready;
  assign bus.instr_ready = advance && !flush;
  assign accept          = bus.instr_valid && bus.instr_ready;

  // Next-state and packet assembly
  always_comb begin
    state_d   = state_q;
    ldm_rd_d  = ldm_rd_q;
    illegal_d = 1'b0;
    issue     = 1'b0;
    pkt_new   = '0;

    if (flush) begin
      state_d  = S_OP;
      ldm_rd_d = '0;
    end else if (accept) begin
      unique case (state_q)
        S_OP: begin
          if (dec_is_two_word) begin
            state_d  = S_IMM;
            ldm_rd_d = dec_rd_addr;
          end else if (dec_is_illegal) begin
            illegal_d = 1'b1;
          end else if (is_single_issue(dec_opcode)) begin
            issue            = 1'b1;
            pkt_new.alu_op   = dec_opcode;
            pkt_new.rs       = bus.rf_rs_data;
            pkt_new.rd       = bus.rf_rd_data;
            pkt_new.dst_addr = dec_rd_addr;
            pkt_new.wb_en    = dec_wb_en;
          end
        end
        S_IMM: begin
          // Whole word is the immediate; its opcode bits are not decoded
          issue             = 1'b1;
          pkt_new.alu_op    = OP_LDM;
          pkt_new.immediate = bus.instr_word;
          pkt_new.dst_addr  = ldm_rd_q;
          pkt_new.wb_en     = 1'b1;
          state_d           = S_OP;
          ldm_rd_d          = '0;
        end
      endcase
    end
  end

  // Packet register and retirement counter
  always_comb begin
    ex_valid_d = ex_valid_q;
    pkt_d      = pkt_q;
    count_d    = count_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else begin
      if (ex_valid_q && bus.ex_ready) begin
        count_d = count_q + 16'd1;
      end
      if (issue) begin
        ex_valid_d = 1'b1;
        pkt_d      = pkt_new;
      end else if (bus.ex_ready) begin
        ex_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      ldm_rd_q   <= '0;
      ex_valid_q <= 1'b0;
      pkt_q      <= '0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ldm_rd_q   <= ldm_rd_d;
      ex_valid_q <= ex_valid_d;
      pkt_q      <= pkt_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_alu_op    = pkt_q.alu_op;
  assign bus.ex_rs        = pkt_q.rs;
  assign bus.ex_rd        = pkt_q.rd;
  assign bus.ex_immediate = pkt_q.immediate;
  assign bus.ex_dst_addr  = pkt_q.dst_addr;
  assign bus.ex_wb_en     = pkt_q.wb_en;
  assign illegal_instr    = illegal_q;
  assign issue_count      = count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with hand-computed expectations.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        illegal_instr;
  logic [15:0] issue_count;

  int n_checks;
  int n_fail;

  alu_issue_if bus ();

  alu_issue_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bus.master),
    .illegal_instr (illegal_instr),
    .issue_count   (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag, input logic [2:0] op, input logic [15:0] rs,
                           input logic [15:0] rd, input logic [15:0] imm,
                           input logic [2:0] dst, input logic wb);
    check_eq({tag, ".valid"}, {31'd0, bus.ex_valid}, 32'd1);
    check_eq({tag, ".op"}, {29'd0, bus.ex_alu_op}, {29'd0, op});
    check_eq({tag, ".rs"}, {16'd0, bus.ex_rs}, {16'd0, rs});
    check_eq({tag, ".rd"}, {16'd0, bus.ex_rd}, {16'd0, rd});
    check_eq({tag, ".imm"}, {16'd0, bus.ex_immediate}, {16'd0, imm});
    check_eq({tag, ".dst"}, {29'd0, bus.ex_dst_addr}, {29'd0, dst});
    check_eq({tag, ".wb"}, {31'd0, bus.ex_wb_en}, {31'd0, wb});
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_word  = 16'h0000;
    bus.rf_rs_data  = 16'h0000;
    bus.rf_rd_data  = 16'h0000;
    bus.ex_ready    = 1'b1;

    // Reset state
    #3;
    check_eq("rst.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("rst.count", {16'd0, issue_count}, 32'd0);
    check_eq("rst.illegal", {31'd0, illegal_instr}, 32'd0);
    check_eq("rst.op", {29'd0, bus.ex_alu_op}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("idle.ready", {31'd0, bus.instr_ready}, 32'd1);
    check_eq("idle.ex_valid", {31'd0, bus.ex_valid}, 32'd0);

    // Register-file addresses follow the word combinationally
    bus.instr_word = 16'h2800;
    #1;
    check_eq("rf.rd_addr", {29'd0, bus.rf_rd_addr}, 32'd2);
    check_eq("rf.rs_addr", {29'd0, bus.rf_rs_addr}, 32'd0);
    bus.instr_word = 16'h8E00;
    #1;
    check_eq("rf.rd_addr2", {29'd0, bus.rf_rd_addr}, 32'd3);
    check_eq("rf.rs_addr2", {29'd0, bus.rf_rs_addr}, 32'd4);

    // ADD r1, r1
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h6480;
    bus.rf_rs_data  = 16'h0005;
    bus.rf_rd_data  = 16'h0003;
    step();
    bus.instr_valid = 1'b0;
    check_pkt("add", 3'd3, 16'h0005, 16'h0003, 16'h0000, 3'd1, 1'b1);
    check_eq("add.count_before", {16'd0, issue_count}, 32'd0);
    step();
    check_eq("add.count", {16'd0, issue_count}, 32'd1);
    check_eq("add.retired", {31'd0, bus.ex_valid}, 32'd0);

    // LDM r2, #0xBEEF
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h2800;
    step();
    check_eq("ldm.no_issue", {31'd0, bus.ex_valid}, 32'd0);
    bus.instr_word = 16'hBEEF;
    step();
    bus.instr_valid = 1'b0;
    check_pkt("ldm", 3'd1, 16'h0000, 16'h0000, 16'hBEEF, 3'd2, 1'b1);
    step();
    check_eq("ldm.count", {16'd0, issue_count}, 32'd2);

    // NOT r3, r4 held for 3 cycles, STD queued behind it
    bus.ex_ready    = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h8E00;
    bus.rf_rs_data  = 16'h1234;
    bus.rf_rd_data  = 16'h00FF;
    step();
    bus.instr_word = 16'h5700;
    bus.rf_rs_data = 16'hAAAA;
    bus.rf_rd_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall.ready", {31'd0, bus.instr_ready}, 32'd0);
      check_pkt("stall.not", 3'd4, 16'h1234, 16'h00FF, 16'h0000, 3'd3, 1'b1);
      step();
    end
    bus.ex_ready = 1'b1;
    #1;
    check_eq("release.ready", {31'd0, bus.instr_ready}, 32'd1);
    step();
    bus.instr_valid = 1'b0;
    check_pkt("std", 3'd2, 16'hAAAA, 16'h5555, 16'h0000, 3'd5, 1'b0);
    check_eq("std.count", {16'd0, issue_count}, 32'd3);
    step();
    check_eq("std.retired", {16'd0, issue_count}, 32'd4);

    // Flush while waiting for the LDM immediate
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h2800;
    step();
    bus.instr_valid = 1'b0;
    flush           = 1'b1;
    #1;
    check_eq("flush.ready", {31'd0, bus.instr_ready}, 32'd0);
    step();
    flush           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h6000;
    bus.rf_rs_data  = 16'h0007;
    bus.rf_rd_data  = 16'h0009;
    step();
    bus.instr_valid = 1'b0;
    check_pkt("flush.add", 3'd3, 16'h0007, 16'h0009, 16'h0000, 3'd0, 1'b1);
    step();
    check_eq("flush.add_count", {16'd0, issue_count}, 32'd5);

    // Flush coincident with ex_ready kills the packet without counting it
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h6480;
    step();
    bus.instr_valid = 1'b0;
    flush           = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush.kill_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("flush.kill_count", {16'd0, issue_count}, 32'd5);

    // Illegal opcode
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'hE000;
    step();
    bus.instr_valid = 1'b0;
    check_eq("illegal.pulse", {31'd0, illegal_instr}, 32'd1);
    check_eq("illegal.no_issue", {31'd0, bus.ex_valid}, 32'd0);
    step();
    check_eq("illegal.once", {31'd0, illegal_instr}, 32'd0);

    // Immediate word with an illegal-looking opcode is still just data
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h2C00;
    step();
    bus.instr_word = 16'hE123;
    step();
    bus.instr_valid = 1'b0;
    check_pkt("ldm_e", 3'd1, 16'h0000, 16'h0000, 16'hE123, 3'd3, 1'b1);
    check_eq("ldm_e.no_illegal", {31'd0, illegal_instr}, 32'd0);
    step();
    check_eq("ldm_e.count", {16'd0, issue_count}, 32'd6);

    // Back-to-back issues up to the counter wrap
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h6480;
    for (int i = 0; i < 65529; i++) begin
      step();
    end
    bus.instr_valid = 1'b0;
    step();
    check_eq("wrap.max", {16'd0, issue_count}, 32'h0000_FFFF);
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    check_eq("wrap.zero", {16'd0, issue_count}, 32'd0);

    // Async reset mid-stall
    bus.instr_valid = 1'b1;
    bus.rf_rs_data  = 16'h0011;
    step();
    step();
    bus.instr_valid = 1'b0;
    bus.ex_ready    = 1'b0;
    step();
    check_eq("stall2.valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("stall2.count", {16'd0, issue_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("arst.count", {16'd0, issue_count}, 32'd0);
    check_eq("arst.op", {29'd0, bus.ex_alu_op}, 32'd0);
    check_eq("arst.rs", {16'd0, bus.ex_rs}, 32'd0);
    check_eq("arst.wb", {31'd0, bus.ex_wb_en}, 32'd0);
    step();
    rst_n        = 1'b1;
    bus.ex_ready = 1'b1;

    // Async reset mid-LDM loses the opcode word
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h2800;
    step();
    rst_n = 1'b0;
    #1;
    rst_n          = 1'b1;
    bus.instr_word = 16'h6000;
    bus.rf_rs_data = 16'h0002;
    bus.rf_rd_data = 16'h0004;
    step();
    bus.instr_valid = 1'b0;
    check_pkt("arst_ldm.add", 3'd3, 16'h0002, 16'h0004, 16'h0000, 3'd0, 1'b1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
